// File: rtl/seg8_scan_controller.sv
// seg8_scan_controller
// Loads a binary value, converts it to eight BCD digits one bit per cycle
// (shift-add-3), and time-multiplexes the committed digits onto eight
// active-low anodes. Code 4'hF is the blank code for the external decoder.
//
// state | meaning
// IDLE  | waiting for a load; display shows the last committed value
// CONV  | shifting one input bit per cycle into the BCD scratch
module seg8_scan_controller #(
    parameter int DATA_W  = 27,
    parameter int CLK_DIV = 100000,
    parameter bit LZB     = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] bin_in,
    input  logic              load,
    output logic              busy,
    output logic              ovf,
    output logic [3:0]        digit,
    output logic [7:0]        anode
);

    localparam int CNT_W = $clog2(DATA_W + 1);
    localparam int PS_W  = $clog2(CLK_DIV);

    typedef enum logic {IDLE, CONV} state_t;

    state_t            state;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] nsh;
    logic [31:0]       scratch;
    logic [31:0]       adj;
    logic [31:0]       nscr;
    logic [31:0]       disp;
    logic [CNT_W-1:0]  cnt;
    logic              ovf_pending;
    logic              ovf_cmp;
    logic [PS_W-1:0]   presc;
    logic [2:0]        idx;
    logic              upper_zero;
    logic [3:0]        nib_sel;

    // Only a full 27-bit input can exceed eight decimal digits.
    generate
        if (DATA_W >= 27) begin : g_ovf
            assign ovf_cmp = (32'(bin_in) > 32'd99_999_999);
        end else begin : g_no_ovf
            assign ovf_cmp = 1'b0;
        end
    endgenerate

    // Add 3 to every scratch nibble that is 5 or more, ahead of the shift.
    always_comb begin
        adj = '0;
        for (int k = 0; k < 8; k++) begin
            if (scratch[4*k +: 4] >= 4'd5)
                adj[4*k +: 4] = scratch[4*k +: 4] + 4'd3;
            else
                adj[4*k +: 4] = scratch[4*k +: 4];
        end
    end

    // One-bit left shift of {scratch, shift}; the top scratch bit is dropped.
    assign {nscr, nsh} = {adj[30:0], shift, 1'b0};

    // Conversion FSM; disp and ovf commit together on the final shift.
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            shift       <= '0;
            scratch     <= '0;
            cnt         <= '0;
            ovf_pending <= 1'b0;
            disp        <= '0;
            ovf         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (load) begin
                        shift       <= bin_in;
                        scratch     <= '0;
                        cnt         <= CNT_W'(DATA_W);
                        ovf_pending <= ovf_cmp;
                        state       <= CONV;
                    end
                end
                CONV: begin
                    scratch <= nscr;
                    shift   <= nsh;
                    cnt     <= cnt - 1'b1;
                    if (cnt == CNT_W'(1)) begin
                        disp  <= nscr;
                        ovf   <= ovf_pending;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state == CONV);

    // Scan prescaler and digit index; free-running, independent of loads.
    always_ff @(posedge clk) begin
        if (rst) begin
            presc <= '0;
            idx   <= '0;
        end else if (presc == PS_W'(CLK_DIV - 1)) begin
            presc <= '0;
            idx   <= idx + 3'd1;
        end else begin
            presc <= presc + 1'b1;
        end
    end

    // Digit select with overflow and leading-zero blanking, from registers only.
    always_comb begin
        upper_zero = 1'b1;
        for (int k = 0; k < 8; k++) begin
            if ((k >= int'(idx)) && (disp[4*k +: 4] != 4'd0))
                upper_zero = 1'b0;
        end
        nib_sel = disp[{idx, 2'b00} +: 4];
        if (ovf)
            digit = 4'hF;
        else if (LZB && (idx != 3'd0) && upper_zero)
            digit = 4'hF;
        else
            digit = nib_sel;
    end

    assign anode = ~(8'b1 << idx);

endmodule

// File: tb/tb_seg8_scan_controller.sv
// Directed bench for seg8_scan_controller: one instance with leading-zero
// blanking, one without, sharing clock, reset and load inputs.
module tb_seg8_scan_controller;

    localparam int DW = 27;
    localparam int CD = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          load = 1'b0;
    logic [DW-1:0] bin_in = '0;
    logic          busy1, ovf1, busy0, ovf0;
    logic [3:0]    dig1, dig0;
    logic [7:0]    an1, an0;

    int            vectors = 0;
    int            errors = 0;
    logic [31:0]   cap1, cap0;

    seg8_scan_controller #(.DATA_W(DW), .CLK_DIV(CD), .LZB(1'b1)) u_dut_lzb (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
        .busy(busy1), .ovf(ovf1), .digit(dig1), .anode(an1)
    );

    seg8_scan_controller #(.DATA_W(DW), .CLK_DIV(CD), .LZB(1'b0)) u_dut_nolzb (
        .clk(clk), .rst(rst), .bin_in(bin_in), .load(load),
        .busy(busy0), .ovf(ovf0), .digit(dig0), .anode(an0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic int pos_of(input logic [7:0] an);
        logic [7:0] pat;
        pos_of = -1;
        for (int k = 0; k < 8; k++) begin
            pat = ~(8'b1 << k);
            if (an === pat) pos_of = k;
        end
    endfunction

    // Observe one full refresh period and assemble the shown digits as a word.
    task automatic capture();
        int bad = 0;
        int p;
        cap1 = '0;
        cap0 = '0;
        for (int n = 0; n < 8*CD; n++) begin
            @(negedge clk);
            p = pos_of(an1);
            if (p < 0 || an0 !== an1) begin
                bad++;
            end else begin
                cap1[4*p +: 4] = dig1;
                cap0[4*p +: 4] = dig0;
            end
        end
        chk("anode_onehot", 32'(bad), 32'd0);
    endtask

    // Load a value, measure busy length, and confirm the old value stays shown.
    task automatic do_load(input logic [DW-1:0] v, input logic [31:0] old1);
        int n = 0;
        int stale = 0;
        int p;
        @(negedge clk);
        bin_in = v;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        while (busy1 && n < 100) begin
            p = pos_of(an1);
            if (p >= 0 && dig1 !== old1[4*p +: 4]) stale++;
            @(posedge clk);
            #1;
            n++;
        end
        chk("busy_cycles", 32'(n), 32'd27);
        chk("stale_display", 32'(stale), 32'd0);
    endtask

    initial begin
        int nb;
        int n;
        logic b27, b28;
        logic [7:0] exp_an;

        // Reset and scan sequence
        repeat (3) @(posedge clk);
        @(negedge clk);
        for (int i = 0; i < 36; i++) begin
            if (i > 0) @(negedge clk);
            exp_an = ~(8'b1 << ((i / CD) % 8));
            chk("rst_anode", 32'(an1), 32'(exp_an));
            chk("rst_digit_lzb", 32'(dig1), (exp_an == 8'hFE) ? 32'h0 : 32'hF);
            chk("rst_digit_nolzb", 32'(dig0), 32'h0);
            if (i == 0) rst = 1'b0;
        end
        chk("rst_busy", 32'(busy1), 32'd0);
        chk("rst_ovf", 32'(ovf1), 32'd0);

        // Basic conversion
        do_load(27'd12_345_678, 32'hFFFF_FFF0);
        capture();
        chk("basic_lzb", cap1, 32'h1234_5678);
        chk("basic_nolzb", cap0, 32'h1234_5678);
        chk("basic_ovf", 32'(ovf1), 32'd0);

        // Leading-zero blanking and zero
        do_load(27'd1_002, 32'h1234_5678);
        capture();
        chk("v1002_lzb", cap1, 32'hFFFF_1002);
        chk("v1002_nolzb", cap0, 32'h0000_1002);
        do_load(27'd0, 32'hFFFF_1002);
        capture();
        chk("zero_lzb", cap1, 32'hFFFF_FFF0);
        chk("zero_nolzb", cap0, 32'h0000_0000);

        // Overflow, then largest legal value
        do_load(27'd100_000_000, 32'hFFFF_FFF0);
        chk("ovf_set", 32'(ovf1), 32'd1);
        capture();
        chk("ovf_lzb", cap1, 32'hFFFF_FFFF);
        chk("ovf_nolzb", cap0, 32'hFFFF_FFFF);
        do_load(27'd99_999_999, 32'hFFFF_FFFF);
        chk("ovf_clr", 32'(ovf1), 32'd0);
        capture();
        chk("max_lzb", cap1, 32'h9999_9999);
        chk("max_nolzb", cap0, 32'h9999_9999);

        // Loads while busy are dropped, not queued
        @(negedge clk);
        bin_in = 27'd5;
        load = 1'b1;
        @(posedge clk);
        #1 bin_in = 27'd7;
        nb = 0;
        for (int k = 1; k <= 27; k++) begin
            @(posedge clk);
            #1;
            if (busy1) nb++;
            if (k == 27) begin
                chk("hs_busy_low", 32'(busy1), 32'd0);
                load = 1'b0;
            end
        end
        chk("hs_busy_count", 32'(nb), 32'd26);
        repeat (3) @(posedge clk);
        #1 chk("hs_not_queued", 32'(busy1), 32'd0);
        capture();
        chk("hs_shows5", cap1, 32'hFFFF_FFF5);

        // Back-to-back: next load accepted at E0+28
        @(negedge clk);
        bin_in = 27'd5;
        load = 1'b1;
        @(posedge clk);
        #1 bin_in = 27'd7;
        b27 = 1'b0;
        b28 = 1'b0;
        for (int k = 1; k <= 28; k++) begin
            @(posedge clk);
            #1;
            if (k == 27) b27 = busy1;
            if (k == 28) begin
                b28 = busy1;
                load = 1'b0;
            end
        end
        chk("b2b_idle_e27", 32'(b27), 32'd0);
        chk("b2b_accept_e28", 32'(b28), 32'd1);
        n = 0;
        while (busy1 && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("b2b_second_len", 32'(n), 32'd27);
        capture();
        chk("b2b_shows7", cap1, 32'hFFFF_FFF7);

        // Reset aborts a conversion in progress
        do_load(27'd12_345_678, 32'hFFFF_FFF7);
        @(negedge clk);
        bin_in = 27'd999;
        load = 1'b1;
        @(posedge clk);
        #1 load = 1'b0;
        repeat (9) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("abort_busy", 32'(busy1), 32'd0);
        chk("abort_anode", 32'(an1), 32'hFE);
        chk("abort_digit", 32'(dig1), 32'h0);
        chk("abort_ovf", 32'(ovf1), 32'd0);
        rst = 1'b0;
        repeat (40) @(posedge clk);
        capture();
        chk("abort_lzb", cap1, 32'hFFFF_FFF0);
        chk("abort_nolzb", cap0, 32'h0000_0000);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule

// File: doc/seg8_scan_controller.md
# seg8_scan_controller

Sequencing controller for the 8-digit common-anode seven-segment display. Accepts a binary value through a load handshake and converts it to eight BCD digits with a sequential shift-add-3 (double-dabble) engine. Time-multiplexes the digits onto the shared active-low anodes and drives the 4-bit digit code that the board's BCD-to-cathode decoder turns into cathodes. Codes above 9 produce a blank digit in that decoder; this block uses 4'hF for blanking.

## Interface
- DATA_W, 27, binary input width; legal range 1..27, since 27 bits covers 99_999_999.
- CLK_DIV, 100000, clk cycles per digit slot; legal range >= 2.
- LZB, 1, leading-zero blanking enable (1 = blank leading zeros).
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  synchronous, active-high reset.
- bin_in  in  DATA_W  unsigned value to display; sampled only when a load is accepted.
- load  in  1  load request; accepted when load=1 and busy=0 at a rising edge.
- busy  out  1  conversion in progress; loads are ignored while high.
- ovf  out  1  committed value exceeded 99_999_999.
- digit  out  4  BCD code for the selected position, or 4'hF for blank; goes to the decoder.
- anode  out  8  active-low digit enables; bit k = AN k, exactly one bit low at all times.

## Operation
- Committed display register: disp[31:0], eight nibbles, nibble k = position k.
- The conversion FSM has two states, IDLE and CONV.
- IDLE: on an accepted load, it captures bin_in into a shift register.
  - It clears the BCD scratch, sets bit counter = DATA_W, and latches ovf_pending = (bin_in > 99_999_999).
  - It then moves to CONV.
  - When DATA_W < 27, ovf_pending is constant 0.
- CONV: one bit per cycle.
  - Every scratch nibble >= 5 gets +3.
  - Then {scratch, shift} shifts left by 1 and the counter decrements.
  - When the counter reaches 0, disp <= scratch, ovf <= ovf_pending, and the FSM returns to IDLE.
  - disp and ovf update atomically, so no partial value is ever displayed.
- busy = (state == CONV).
- load while busy is ignored and not queued. bin_in changes during CONV have no effect.
- Scan: a prescaler counts 0..CLK_DIV-1.
  - At CLK_DIV-1 the prescaler returns to 0 and the 3-bit index idx increments.
  - idx wraps 7 -> 0.
- anode = ~(8'b1 << idx), taken from the registered idx.
- digit is a function of registers only (disp, ovf, idx), with no combinational path from inputs:
  - if ovf = 1: digit = 4'hF;
  - else if LZB = 1, idx != 0, and nibbles idx..7 of disp are all zero: digit = 4'hF;
  - else digit = disp nibble idx.
- Position 0 is never blanked by LZB, so a value of 0 shows as a single "0".

## Timing
- Reset, when rst=1 at an edge:
  - state = IDLE, busy = 0, ovf = 0, disp = 0, prescaler = 0, idx = 0.
  - Outputs become anode = 8'b1111_1110 and digit = 4'h0; with LZB=1, all other positions show blank.
- Reset takes priority over load and aborts any conversion in progress.
  - The old disp is discarded (disp = 0), not committed.
- Load accepted at edge E0:
  - busy = 1 for exactly DATA_W cycles after E0.
  - disp and ovf commit at edge E0+DATA_W.
  - busy = 0 after E0+DATA_W.
  - A new load is accepted at edge E0+DATA_W+1 at the earliest.
- Throughput: one conversion per DATA_W+1 cycles.
- During CONV the previous disp keeps being displayed; scanning never stalls.
- anode and digit change in the same cycle; no cycle shows a mismatched anode/digit pair.
- Each position is selected for exactly CLK_DIV cycles; the full refresh period is 8*CLK_DIV cycles.
- Scan phase is independent of loads. The conversion FSM and scan counter share no state except disp/ovf.

## Test plan
- Reset behaviour: assert rst for 3 cycles, then release with CLK_DIV=4.
  - anode steps FE, FD, FB, F7, EF, DF, BF, 7F, FE, each held 4 cycles.
  - digit = 0 only while anode=FE and 4'hF elsewhere (LZB=1); busy=0, ovf=0.
- Basic conversion: load bin_in=12_345_678 at edge E0.
  - busy is high for 27 cycles.
  - After E0+27, positions 7..0 show 1,2,3,4,5,6,7,8.
  - Before E0+27 the display still shows 0.
- Blanking and edge value: load 1_002.
  - Positions 3..0 = 1,0,0,2; positions 7..4 = 4'hF.
  - Then load 0: position 0 = 0, all others 4'hF.
  - Repeat with LZB=0: leading positions = 0.
- Overflow: load 100_000_000 (DATA_W=27).
  - After commit, ovf=1 and every digit = 4'hF.
  - Then load 99_999_999: ovf=0 and all positions = 9.
- Handshake: accept load=5, then pulse load=7 with bin_in=7 at cycles 1..27.
  - The pulses are ignored; the display shows 5.
  - A load at E0+28 is accepted, and 7 appears after E0+55.
- Reset mid-conversion: after 12_345_678 is displayed, load 999 and assert rst at cycle 10.
  - busy=0, disp=0, anode=FE on the next cycle; the 999 is never displayed.
